// File: rtl/eeprom_seq_pkg.sv
// Shared definitions for the EEPROM request sequencer: state encoding,
// engine command codes, counter width and default timing constants.
package eeprom_seq_pkg;

    localparam int CNT_W     = 24;
    localparam int CNT_LIMIT = 32'sd1 <<< CNT_W;

    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_WR   = 2'b01;
    localparam logic [1:0] CMD_RD   = 2'b10;

    // 5 ms / 40 ms / 4 cycles at 50 MHz
    localparam int TWR_CYCLES_DEF     = 32'sd250000;
    localparam int TIMEOUT_CYCLES_DEF = 32'sd2000000;
    localparam int ENG_RST_CYCLES_DEF = 32'sd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ABORT = 3'd3,
        ST_TWR   = 3'd4
    } seqState_t;

    // The timer flags done when it reaches zero, so a span of N cycles
    // is loaded as N-1.
    function automatic logic [CNT_W-1:0] termCount(input int cycles);
        return CNT_W'(cycles - 32'sd1);
    endfunction

endpackage

// File: rtl/i2c_cycle_timer.sv
// Load/enable down-counter with a zero flag. Load has priority over
// counting; the count saturates at zero.
module i2c_cycle_timer
    import eeprom_seq_pkg::*;
(
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             load,
    input  logic [CNT_W-1:0] loadVal,
    input  logic             en,
    output logic             cntDone
);

    logic [CNT_W-1:0] count_r;

    // Count register: load, otherwise decrement while enabled and non-zero.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= loadVal;
        end else if (en && (count_r != {CNT_W{1'b0}})) begin
            count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign cntDone = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/eeprom_req_sequencer.sv
// Command stage in front of the I2C EEPROM engine: accepts one read or
// write request, holds the engine command until Done_Sig, returns the
// response, enforces the tWR gap after writes and resets a hung engine.
module eeprom_req_sequencer
    import eeprom_seq_pkg::*;
#(
    parameter int TWR_CYCLES     = TWR_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int ENG_RST_CYCLES = ENG_RST_CYCLES_DEF
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       Req_Valid,
    output logic       Req_Ready,
    input  logic       Req_Wr,
    input  logic [7:0] Req_Addr,
    input  logic [7:0] Req_WrData,
    output logic       Rsp_Valid,
    output logic       Rsp_Err,
    output logic [7:0] Rsp_RdData,
    output logic [1:0] Start_Sig,
    output logic [7:0] Addr_Sig,
    output logic [7:0] WrData,
    input  logic [7:0] RdData,
    input  logic       Done_Sig,
    output logic       Eng_RSTn,
    output logic       Busy
);

    if ((TWR_CYCLES < 32'sd1) || (TWR_CYCLES >= CNT_LIMIT) ||
        (TIMEOUT_CYCLES < 32'sd1) || (TIMEOUT_CYCLES >= CNT_LIMIT) ||
        (ENG_RST_CYCLES < 32'sd1) || (ENG_RST_CYCLES >= CNT_LIMIT)) begin : g_param_check
        $error("eeprom_req_sequencer: timing parameters must be in 1 .. 2^24-1");
    end

    seqState_t        state_r;
    seqState_t        nextState_s;
    logic             cmdWr_r;
    logic             cmdWrNext_s;
    logic             accept_s;
    logic             reqReadyNext_s;
    logic [1:0]       startNext_s;
    logic [7:0]       addrNext_s;
    logic [7:0]       wrDataNext_s;
    logic             rspValidNext_s;
    logic             rspErrNext_s;
    logic [7:0]       rspRdDataNext_s;
    logic             engRstnNext_s;
    logic             tmrLoad_s;
    logic [CNT_W-1:0] tmrLoadVal_s;
    logic             tmrEn_s;
    logic             tmrDone_s;

    assign accept_s = Req_Valid & Req_Ready;

    // One timer serves the timeout, the engine-reset pulse and tWR; they never overlap.
    i2c_cycle_timer u_timer (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .load    (tmrLoad_s),
        .loadVal (tmrLoadVal_s),
        .en      (tmrEn_s),
        .cntDone (tmrDone_s)
    );

    // Next-state and next-output decode; every output defaults to its idle or held value.
    always_comb begin
        nextState_s     = state_r;
        cmdWrNext_s     = cmdWr_r;
        reqReadyNext_s  = 1'b0;
        startNext_s     = Start_Sig;
        addrNext_s      = Addr_Sig;
        wrDataNext_s    = WrData;
        rspValidNext_s  = 1'b0;
        rspErrNext_s    = 1'b0;
        rspRdDataNext_s = 8'h00;
        engRstnNext_s   = 1'b1;
        tmrLoad_s       = 1'b0;
        tmrLoadVal_s    = {CNT_W{1'b0}};
        tmrEn_s         = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    cmdWrNext_s  = Req_Wr;
                    addrNext_s   = Req_Addr;
                    wrDataNext_s = Req_WrData;
                    nextState_s  = ST_ISSUE;
                end else begin
                    reqReadyNext_s = 1'b1;
                end
            end
            ST_ISSUE: begin
                startNext_s  = cmdWr_r ? CMD_WR : CMD_RD;
                tmrLoad_s    = 1'b1;
                tmrLoadVal_s = termCount(TIMEOUT_CYCLES);
                nextState_s  = ST_WAIT;
            end
            ST_WAIT: begin
                // Done_Sig is tested first so it wins over a coincident timeout.
                if (Done_Sig) begin
                    startNext_s    = CMD_NONE;
                    rspValidNext_s = 1'b1;
                    if (cmdWr_r) begin
                        tmrLoad_s    = 1'b1;
                        tmrLoadVal_s = termCount(TWR_CYCLES);
                        nextState_s  = ST_TWR;
                    end else begin
                        rspRdDataNext_s = RdData;
                        nextState_s     = ST_IDLE;
                    end
                end else if (tmrDone_s) begin
                    startNext_s   = CMD_NONE;
                    engRstnNext_s = 1'b0;
                    tmrLoad_s     = 1'b1;
                    tmrLoadVal_s  = termCount(ENG_RST_CYCLES);
                    nextState_s   = ST_ABORT;
                end else begin
                    tmrEn_s = 1'b1;
                end
            end
            ST_ABORT: begin
                if (tmrDone_s) begin
                    rspValidNext_s = 1'b1;
                    rspErrNext_s   = 1'b1;
                    nextState_s    = ST_IDLE;
                end else begin
                    engRstnNext_s = 1'b0;
                    tmrEn_s       = 1'b1;
                end
            end
            ST_TWR: begin
                if (tmrDone_s) begin
                    nextState_s = ST_IDLE;
                end else begin
                    tmrEn_s = 1'b1;
                end
            end
            default: begin
                startNext_s = CMD_NONE;
                nextState_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_r    <= ST_IDLE;
            cmdWr_r    <= 1'b0;
            Req_Ready  <= 1'b1;
            Start_Sig  <= CMD_NONE;
            Addr_Sig   <= 8'h00;
            WrData     <= 8'h00;
            Rsp_Valid  <= 1'b0;
            Rsp_Err    <= 1'b0;
            Rsp_RdData <= 8'h00;
            Eng_RSTn   <= 1'b1;
            Busy       <= 1'b0;
        end else begin
            state_r    <= nextState_s;
            cmdWr_r    <= cmdWrNext_s;
            Req_Ready  <= reqReadyNext_s;
            Start_Sig  <= startNext_s;
            Addr_Sig   <= addrNext_s;
            WrData     <= wrDataNext_s;
            Rsp_Valid  <= rspValidNext_s;
            Rsp_Err    <= rspErrNext_s;
            Rsp_RdData <= rspRdDataNext_s;
            Eng_RSTn   <= engRstnNext_s;
            Busy       <= (nextState_s != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_eeprom_req_sequencer.sv
// Bench for eeprom_req_sequencer: engine model with programmable latency
// and NACK mode, a vector table, directed corner sequences and random
// traffic checked against a memory-level reference model.
module tb_eeprom_req_sequencer;

    localparam int TWR = 20;
    localparam int TMO = 1000;
    localparam int ERC = 4;

    logic       CLK        = 1'b0;
    logic       RSTn       = 1'b0;
    logic       Req_Valid  = 1'b0;
    logic       Req_Wr     = 1'b0;
    logic [7:0] Req_Addr   = 8'h00;
    logic [7:0] Req_WrData = 8'h00;
    logic [7:0] RdData     = 8'h00;
    logic       Done_Sig   = 1'b0;
    logic       Req_Ready, Rsp_Valid, Rsp_Err, Eng_RSTn, Busy;
    logic [7:0] Rsp_RdData, Addr_Sig, WrData;
    logic [1:0] Start_Sig;

    always #5 CLK = ~CLK;

    eeprom_req_sequencer #(
        .TWR_CYCLES     (TWR),
        .TIMEOUT_CYCLES (TMO),
        .ENG_RST_CYCLES (ERC)
    ) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .Req_Valid  (Req_Valid),
        .Req_Ready  (Req_Ready),
        .Req_Wr     (Req_Wr),
        .Req_Addr   (Req_Addr),
        .Req_WrData (Req_WrData),
        .Rsp_Valid  (Rsp_Valid),
        .Rsp_Err    (Rsp_Err),
        .Rsp_RdData (Rsp_RdData),
        .Start_Sig  (Start_Sig),
        .Addr_Sig   (Addr_Sig),
        .WrData     (WrData),
        .RdData     (RdData),
        .Done_Sig   (Done_Sig),
        .Eng_RSTn   (Eng_RSTn),
        .Busy       (Busy)
    );

    int nChecks = 0;
    int nPass   = 0;

    logic [7:0] engMem [256];
    logic [7:0] refMem [256];
    int   engLat   = 1;
    logic engNack  = 1'b0;
    int   engCnt   = 0;
    logic engFired = 1'b0;
    logic bothSeen = 1'b0;

    // Engine model: Done_Sig sampled on the engLat-th rising edge after Start_Sig rises.
    always @(negedge CLK) begin
        Done_Sig = 1'b0;
        if (Start_Sig == 2'b11) bothSeen = 1'b1;
        if (!RSTn || !Eng_RSTn || Start_Sig == 2'b00) begin
            engCnt   = 0;
            engFired = 1'b0;
        end else if (!engFired) begin
            engCnt++;
            if (!engNack && engCnt >= engLat) begin
                Done_Sig = 1'b1;
                engFired = 1'b1;
                if (Start_Sig == 2'b01) begin
                    engMem[Addr_Sig] = WrData;
                    RdData = 8'h5C;
                end else begin
                    RdData = engMem[Addr_Sig];
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Issue one request and observe it until the response and any post-response Ready gap.
    task automatic doReq(input logic wr, input logic [7:0] a, input logic [7:0] d,
                         input int lat, input logic nack,
                         output logic rErr, output logic [7:0] rData, output logic rReady,
                         output logic [1:0] sCmd, output logic [7:0] sAddr,
                         output logic [7:0] sData, output logic sBusy,
                         output int latency, output int rstLow, output int rstStart,
                         output int postLow);
        int   startCyc;
        logic gotRsp;
        int   n;
        rErr = 1'b0; rData = 8'h00; rReady = 1'b1; sCmd = 2'b00; sAddr = 8'h00;
        sData = 8'h00; sBusy = 1'b0; latency = -1; rstLow = 0; rstStart = -1;
        postLow = 0; startCyc = -1; gotRsp = 1'b0;
        engLat  = lat;
        engNack = nack;
        @(negedge CLK);
        n = 0;
        while (!Req_Ready && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("ready_before_req", Req_Ready, 1'b1);
        Req_Valid = 1'b1; Req_Wr = wr; Req_Addr = a; Req_WrData = d;
        @(negedge CLK);
        Req_Valid = 1'b0; Req_Wr = 1'($urandom); Req_Addr = 8'($urandom);
        Req_WrData = 8'($urandom);
        for (int cyc = 1; cyc < 3000 && !gotRsp; cyc++) begin
            @(negedge CLK);
            if (startCyc < 0 && Start_Sig != 2'b00) begin
                startCyc = cyc; sCmd = Start_Sig; sAddr = Addr_Sig; sData = WrData; sBusy = Busy;
            end
            if (!Eng_RSTn) begin
                if (rstLow == 0 && startCyc >= 0) rstStart = cyc - startCyc;
                rstLow++;
            end
            if (Rsp_Valid) begin
                gotRsp = 1'b1; rErr = Rsp_Err; rData = Rsp_RdData; rReady = Req_Ready;
                if (startCyc >= 0) latency = cyc - startCyc;
            end
        end
        check("rsp_seen", gotRsp, 1'b1);
        n = 0;
        while (gotRsp && n < 500) begin
            @(negedge CLK);
            n++;
            if (Req_Ready) break;
            postLow++;
        end
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] a;
        logic [7:0] d;
        int         lat;
        logic       nack;
        logic       expErr;
        logic [7:0] expRd;
        int         expPost;
        int         expRstLow;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic       rErr, rReady, sBusy;
        logic [7:0] rData, sAddr, sData;
        logic [1:0] sCmd;
        int         latency, rstLow, rstStart, postLow, n, gap, seen;

        for (int i = 0; i < 256; i++) begin
            engMem[i] = 8'(i) ^ 8'hFF;
            refMem[i] = 8'(i) ^ 8'hFF;
        end

        vecs[0] = '{1'b1, 8'h12, 8'hA5, 500,  1'b0, 1'b0, 8'h00, TWR, 0};
        vecs[1] = '{1'b0, 8'h12, 8'h00, 7,    1'b0, 1'b0, 8'hA5, 0,   0};
        vecs[2] = '{1'b1, 8'h34, 8'h5A, 3,    1'b0, 1'b0, 8'h00, TWR, 0};
        vecs[3] = '{1'b0, 8'h34, 8'h00, 1,    1'b0, 1'b0, 8'h5A, 0,   0};
        vecs[4] = '{1'b1, 8'h56, 8'hC3, 1,    1'b1, 1'b1, 8'h00, 0,   ERC};
        vecs[5] = '{1'b0, 8'h56, 8'h00, 4,    1'b0, 1'b0, 8'hA9, 0,   0};
        vecs[6] = '{1'b0, 8'h12, 8'h00, 1,    1'b1, 1'b1, 8'h00, 0,   ERC};
        vecs[7] = '{1'b0, 8'h12, 8'h00, 2,    1'b0, 1'b0, 8'hA5, 0,   0};
        vecs[8] = '{1'b1, 8'hFF, 8'h01, TMO,  1'b0, 1'b0, 8'h00, TWR, 0};
        vecs[9] = '{1'b0, 8'hFF, 8'h00, TMO-1, 1'b0, 1'b0, 8'h01, 0,  0};

        // Reset values, held in reset and just after release.
        repeat (3) @(negedge CLK);
        check("rst_req_ready", Req_Ready, 1'b1);
        check("rst_start", Start_Sig, 2'b00);
        check("rst_addr_wrdata", {Addr_Sig, WrData}, 16'h0000);
        check("rst_rsp", {Rsp_Valid, Rsp_Err, Rsp_RdData}, 10'h000);
        check("rst_eng_rstn", Eng_RSTn, 1'b1);
        check("rst_busy", Busy, 1'b0);
        RSTn = 1'b1;
        @(negedge CLK);
        check("post_rst_ready", Req_Ready, 1'b1);

        // Vector table.
        for (int i = 0; i < 10; i++) begin
            doReq(vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].lat, vecs[i].nack,
                  rErr, rData, rReady, sCmd, sAddr, sData, sBusy,
                  latency, rstLow, rstStart, postLow);
            check($sformatf("v%0d_err", i), rErr, vecs[i].expErr);
            check($sformatf("v%0d_rddata", i), rData, vecs[i].expRd);
            check($sformatf("v%0d_cmd", i), sCmd, vecs[i].wr ? 2'b01 : 2'b10);
            check($sformatf("v%0d_addr", i), sAddr, vecs[i].a);
            if (vecs[i].wr) check($sformatf("v%0d_wrdata", i), sData, vecs[i].d);
            check($sformatf("v%0d_busy", i), sBusy, 1'b1);
            check($sformatf("v%0d_ready_in_rsp", i), rReady, 1'b0);
            check($sformatf("v%0d_post_ready_low", i), postLow, vecs[i].expPost);
            check($sformatf("v%0d_eng_rst_len", i), rstLow, vecs[i].expRstLow);
            if (vecs[i].nack) check($sformatf("v%0d_eng_rst_start", i), rstStart, TMO);
            else check($sformatf("v%0d_latency", i), latency, vecs[i].lat);
        end

        // Back-to-back reads with Req_Valid held across the response.
        @(negedge CLK);
        engLat = 3; engNack = 1'b0;
        Req_Valid = 1'b1; Req_Wr = 1'b0; Req_Addr = 8'h34;
        n = 0;
        while (!Rsp_Valid && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("b2b_rsp1", {Rsp_Valid, Rsp_RdData}, {1'b1, 8'h5A});
        check("b2b_ready_in_rsp", Req_Ready, 1'b0);
        gap = (Start_Sig == 2'b00) ? 1 : 0;
        @(negedge CLK);
        check("b2b_ready_after_rsp", Req_Ready, 1'b1);
        if (Start_Sig == 2'b00) gap++;
        @(negedge CLK);
        Req_Valid = 1'b0;
        check("b2b_accepted", {Req_Ready, Busy}, 2'b01);
        n = 0;
        while (Start_Sig == 2'b00 && n < 50) begin
            gap++;
            @(negedge CLK);
            n++;
        end
        check("b2b_start_gap", (gap >= 1) ? 1'b1 : 1'b0, 1'b1);
        check("b2b_cmd2", Start_Sig, 2'b10);
        n = 0;
        while (!Rsp_Valid && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("b2b_rsp2", {Rsp_Valid, Rsp_Err, Rsp_RdData}, {1'b1, 1'b0, 8'h5A});

        // RSTn pulsed low while a request waits on a silent engine.
        repeat (2) @(negedge CLK);
        engNack = 1'b1;
        Req_Valid = 1'b1; Req_Wr = 1'b0; Req_Addr = 8'h12;
        @(negedge CLK);
        Req_Valid = 1'b0;
        repeat (50) @(negedge CLK);
        check("midrst_busy_before", {Busy, Start_Sig}, 3'b110);
        RSTn = 1'b0;
        #1;
        check("midrst_outputs",
              {Req_Ready, Start_Sig, Addr_Sig, WrData, Rsp_Valid, Rsp_Err, Rsp_RdData, Eng_RSTn, Busy},
              {1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
        @(negedge CLK);
        RSTn = 1'b1;
        engNack = 1'b0;
        seen = 0;
        for (int c = 0; c < TMO + 100; c++) begin
            @(negedge CLK);
            if (Rsp_Valid) seen++;
        end
        check("midrst_no_rsp", seen, 0);
        doReq(1'b0, 8'h12, 8'h00, 5, 1'b0, rErr, rData, rReady, sCmd, sAddr, sData, sBusy,
              latency, rstLow, rstStart, postLow);
        check("midrst_next_read", {rErr, rData}, {1'b0, 8'hA5});

        // Random traffic against the memory-level reference model.
        for (int k = 0; k < 40; k++) begin
            logic       wr, nack;
            logic [7:0] a, d, expRd;
            int         lat;
            wr   = 1'($urandom);
            a    = 8'h80 + 8'($urandom_range(0, 7));
            d    = 8'($urandom);
            lat  = $urandom_range(1, 40);
            nack = ($urandom_range(0, 9) == 0);
            expRd = (wr || nack) ? 8'h00 : refMem[a];
            if (wr && !nack) refMem[a] = d;
            doReq(wr, a, d, lat, nack, rErr, rData, rReady, sCmd, sAddr, sData, sBusy,
                  latency, rstLow, rstStart, postLow);
            check($sformatf("r%0d_err", k), rErr, nack);
            check($sformatf("r%0d_rddata", k), rData, expRd);
            check($sformatf("r%0d_cmd_addr", k), {sCmd, sAddr}, {(wr ? 2'b01 : 2'b10), a});
            check($sformatf("r%0d_post_ready_low", k), postLow, (wr && !nack) ? TWR : 0);
        end

        check("start_never_both", bothSeen, 1'b0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
